// File: rtl/load_order_buffer_pkg.sv
// -----------------------------------------------------------------------------
// load_order_buffer_pkg
// Shared types and helpers for the load order buffer:
//   - default depth, ROB tag / SSIT / LFST widths
//   - lb_entry_t: one recorded load (valid, word address, mask, tag, store-set info)
//   - rob_age(): distance of a ROB tag from the ROB head (smaller = older)
// -----------------------------------------------------------------------------
package load_order_buffer_pkg;

  localparam int LB_DEPTH_DEFAULT = 16;
  localparam int ROB_TAG_W        = 5;
  localparam int ROB_SIZE_DEFAULT = 32;
  localparam int SSIT_WIDTH       = 10;
  localparam int LFST_WIDTH       = 7;

  typedef logic [ROB_TAG_W-1:0]  rob_tag_t;
  typedef logic [SSIT_WIDTH-1:0] ssit_pc_t;
  typedef logic [LFST_WIDTH-1:0] lfst_id_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] word_addr;
    logic [3:0]  mask;
    rob_tag_t    rob_tag;
    ssit_pc_t    ssit_pc;
    lfst_id_t    lfst_id;
  } lb_entry_t;

  // Modular distance from the ROB head; the tag width makes the wrap implicit.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/load_order_buffer_if.sv
// -----------------------------------------------------------------------------
// load_order_buffer_if
// LSU <-> load buffer channel. The LSU (master) drives load allocation, store
// check, commit and flush requests plus the ROB head; the load buffer (slave)
// returns the full flag and the memory-order violation report.
// -----------------------------------------------------------------------------
interface load_order_buffer_if;
  import load_order_buffer_pkg::*;

  logic        instr_valid_i;
  logic        load_allocate_i;
  logic [31:0] load_allocate_addr_i;
  logic [3:0]  load_allocate_mask_i;
  rob_tag_t    load_allocate_rob_tag_i;
  ssit_pc_t    load_store_set_pc_i;
  lfst_id_t    load_store_set_id_i;
  logic        store_instruction_i;
  logic [31:0] store_addr_i;
  rob_tag_t    store_rob_tag_i;
  rob_tag_t    rob_head_i;
  logic        commit_valid_i;
  rob_tag_t    commit_rob_tag_i;
  logic        flush_i;
  logic        lb_full_o;
  logic        violation_detect_o;
  ssit_pc_t    violation_load_pc_o;
  lfst_id_t    violation_load_id_o;

  modport master (
    output instr_valid_i, load_allocate_i, load_allocate_addr_i, load_allocate_mask_i,
    output load_allocate_rob_tag_i, load_store_set_pc_i, load_store_set_id_i,
    output store_instruction_i, store_addr_i, store_rob_tag_i, rob_head_i,
    output commit_valid_i, commit_rob_tag_i, flush_i,
    input  lb_full_o, violation_detect_o, violation_load_pc_o, violation_load_id_o
  );

  modport slave (
    input  instr_valid_i, load_allocate_i, load_allocate_addr_i, load_allocate_mask_i,
    input  load_allocate_rob_tag_i, load_store_set_pc_i, load_store_set_id_i,
    input  store_instruction_i, store_addr_i, store_rob_tag_i, rob_head_i,
    input  commit_valid_i, commit_rob_tag_i, flush_i,
    output lb_full_o, violation_detect_o, violation_load_pc_o, violation_load_id_o
  );

endinterface

// File: rtl/load_order_buffer_lb_oldest_select.sv
// -----------------------------------------------------------------------------
// lb_oldest_select
// Combinational comparison tree: reduces a hit vector and per-entry ROB ages
// to a one-hot vector marking the hit with the smallest age.
//   i_hit            per-entry hit flags
//   i_age            per-entry age relative to the ROB head
//   o_oldest_onehot  one-hot oldest hit (all zero when no hit)
//   o_any_hit        at least one hit present
// -----------------------------------------------------------------------------
module lb_oldest_select
  import load_order_buffer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic     [N-1:0] i_hit,
  input  rob_tag_t [N-1:0] i_age,
  output logic     [N-1:0] o_oldest_onehot,
  output logic             o_any_hit
);

  localparam int IDX_W = $clog2(N);
  localparam int NODES = 2 * N - 1;

  // Heap-ordered tree: node k has children 2k+1 / 2k+2, leaves at N-1..2N-2.
  logic             w_node_v   [NODES];
  rob_tag_t         w_node_age [NODES];
  logic [IDX_W-1:0] w_node_idx [NODES];

  // Tournament reduction from the leaves up to the root.
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      w_node_v[k]   = 1'b0;
      w_node_age[k] = '0;
      w_node_idx[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      w_node_v[N-1+i]   = i_hit[i];
      w_node_age[N-1+i] = i_age[i];
      w_node_idx[N-1+i] = IDX_W'(i);
    end
    for (int k = N - 2; k >= 0; k--) begin
      if (w_node_v[2*k+1] && (!w_node_v[2*k+2] || (w_node_age[2*k+1] < w_node_age[2*k+2]))) begin
        w_node_v[k]   = 1'b1;
        w_node_age[k] = w_node_age[2*k+1];
        w_node_idx[k] = w_node_idx[2*k+1];
      end else begin
        w_node_v[k]   = w_node_v[2*k+2];
        w_node_age[k] = w_node_age[2*k+2];
        w_node_idx[k] = w_node_idx[2*k+2];
      end
    end
  end

  // Decode the winning index at the root.
  always_comb begin
    o_any_hit = w_node_v[0];
    for (int i = 0; i < N; i++) begin
      o_oldest_onehot[i] = w_node_v[0] && (w_node_idx[0] == IDX_W'(i));
    end
  end

endmodule

// File: rtl/load_order_buffer.sv
// -----------------------------------------------------------------------------
// load_order_buffer
// Records executed loads and checks each executing store against them. A valid
// load that is younger than the store and targets the same word is reported one
// cycle later together with its SSIT index and LFST id.
//   clk_i, rst_i  core clock, asynchronous active-high reset
//   lsu           slave side of load_order_buffer_if (requests in, lb_full_o and
//                 violation report out)
// Parameters: LB_DEPTH entries (power of two), ROB_SIZE = 2**$bits(rob_tag_t).
// -----------------------------------------------------------------------------
module load_order_buffer
  import load_order_buffer_pkg::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEFAULT,
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  load_order_buffer_if.slave   lsu
);

  localparam rob_tag_t ROB_MASK = rob_tag_t'(ROB_SIZE - 1);

  lb_entry_t r_entries [LB_DEPTH];
  logic      r_full;
  logic      r_viol;
  ssit_pc_t  r_viol_pc;
  lfst_id_t  r_viol_id;

  logic     [LB_DEPTH-1:0] w_valid;
  logic     [LB_DEPTH-1:0] w_valid_next;
  logic     [LB_DEPTH-1:0] w_free_onehot;
  logic     [LB_DEPTH-1:0] w_commit_hit;
  logic     [LB_DEPTH-1:0] w_hit;
  logic     [LB_DEPTH-1:0] w_oldest;
  rob_tag_t [LB_DEPTH-1:0] w_age;
  rob_tag_t                w_store_age;
  logic                    w_found;
  logic                    w_any_hit;
  logic                    w_alloc_fire;
  logic                    w_store_fire;
  ssit_pc_t                w_sel_pc;
  lfst_id_t                w_sel_id;
  logic                    w_unused_bits;

  assign w_alloc_fire  = lsu.instr_valid_i & lsu.load_allocate_i & ~r_full;
  assign w_store_fire  = lsu.instr_valid_i & lsu.store_instruction_i;
  assign w_unused_bits = ^{lsu.store_addr_i[1:0], lsu.load_allocate_addr_i[1:0]};

  // Per-entry valid view, commit matches, ages and store hits (pre-edge state).
  always_comb begin
    w_store_age = rob_age(lsu.store_rob_tag_i, lsu.rob_head_i) & ROB_MASK;
    for (int i = 0; i < LB_DEPTH; i++) begin
      w_valid[i]      = r_entries[i].valid;
      w_commit_hit[i] = lsu.commit_valid_i && (r_entries[i].rob_tag == lsu.commit_rob_tag_i);
      w_age[i]        = rob_age(r_entries[i].rob_tag, lsu.rob_head_i) & ROB_MASK;
      w_hit[i]        = r_entries[i].valid
                        && (r_entries[i].word_addr == lsu.store_addr_i[31:2])
                        && (w_age[i] > w_store_age)
                        && (r_entries[i].mask != 4'b0000);
    end
  end

  // Lowest-index free slot; only slots free before the edge are candidates.
  always_comb begin
    w_free_onehot = '0;
    w_found       = 1'b0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if (!w_valid[i] && !w_found) begin
        w_free_onehot[i] = 1'b1;
        w_found          = 1'b1;
      end else begin
        w_free_onehot[i] = 1'b0;
      end
    end
  end

  // Next valid vector: flush wipes everything, else commit clears and allocate sets.
  always_comb begin
    if (lsu.flush_i) begin
      w_valid_next = '0;
    end else begin
      w_valid_next = (w_valid & ~w_commit_hit) | ({LB_DEPTH{w_alloc_fire}} & w_free_onehot);
    end
  end

  lb_oldest_select #(
    .N (LB_DEPTH)
  ) u_oldest (
    .i_hit           (w_hit),
    .i_age           (w_age),
    .o_oldest_onehot (w_oldest),
    .o_any_hit       (w_any_hit)
  );

  // One-hot mux of the oldest hit's store-set identifiers.
  always_comb begin
    w_sel_pc = '0;
    w_sel_id = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      w_sel_pc = w_sel_pc | ({SSIT_WIDTH{w_oldest[i]}} & r_entries[i].ssit_pc);
      w_sel_id = w_sel_id | ({LFST_WIDTH{w_oldest[i]}} & r_entries[i].lfst_id);
    end
  end

  // Entry storage: valid bits every cycle, payload only on allocation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        r_entries[i].valid <= w_valid_next[i];
        if (w_alloc_fire && w_free_onehot[i] && !lsu.flush_i) begin
          r_entries[i].word_addr <= lsu.load_allocate_addr_i[31:2];
          r_entries[i].mask      <= lsu.load_allocate_mask_i;
          r_entries[i].rob_tag   <= lsu.load_allocate_rob_tag_i;
          r_entries[i].ssit_pc   <= lsu.load_store_set_pc_i;
          r_entries[i].lfst_id   <= lsu.load_store_set_id_i;
        end
      end
    end
  end

  // Full flag reflects the post-edge occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
    end else begin
      r_full <= &w_valid_next;
    end
  end

  // Violation pulse; identifiers hold their last value between violations.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_viol    <= 1'b0;
      r_viol_pc <= '0;
      r_viol_id <= '0;
    end else if (lsu.flush_i) begin
      r_viol    <= 1'b0;
    end else if (w_store_fire && w_any_hit) begin
      r_viol    <= 1'b1;
      r_viol_pc <= w_sel_pc;
      r_viol_id <= w_sel_id;
    end else begin
      r_viol    <= 1'b0;
    end
  end

  assign lsu.lb_full_o           = r_full;
  assign lsu.violation_detect_o  = r_viol;
  assign lsu.violation_load_pc_o = r_viol_pc;
  assign lsu.violation_load_id_o = r_viol_id;

endmodule

// File: tb/tb_load_order_buffer.sv
// -----------------------------------------------------------------------------
// tb_load_order_buffer
// Directed stimulus with a scoreboard: each store expected to violate pushes
// {cycle, pc, id} into a queue; a monitor pops on every violation pulse.
// -----------------------------------------------------------------------------
module tb_load_order_buffer;
  import load_order_buffer_pkg::*;

  typedef struct {
    int unsigned cyc;
    ssit_pc_t    pc;
    lfst_id_t    id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q [$];

  load_order_buffer_if lsu_if ();

  load_order_buffer #(
    .LB_DEPTH (16),
    .ROB_SIZE (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .lsu   (lsu_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ssit_pc_t pc_of(input rob_tag_t t);
    return ssit_pc_t'(10'h040 + {5'd0, t});
  endfunction

  function automatic lfst_id_t id_of(input rob_tag_t t);
    return lfst_id_t'({2'b00, t} ^ 7'h55);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    lsu_if.instr_valid_i           = 1'b0;
    lsu_if.load_allocate_i         = 1'b0;
    lsu_if.load_allocate_addr_i    = 32'h0;
    lsu_if.load_allocate_mask_i    = 4'h0;
    lsu_if.load_allocate_rob_tag_i = 5'd0;
    lsu_if.load_store_set_pc_i     = 10'd0;
    lsu_if.load_store_set_id_i     = 7'd0;
    lsu_if.store_instruction_i     = 1'b0;
    lsu_if.store_addr_i            = 32'h0;
    lsu_if.store_rob_tag_i         = 5'd0;
    lsu_if.commit_valid_i          = 1'b0;
    lsu_if.commit_rob_tag_i        = 5'd0;
    lsu_if.flush_i                 = 1'b0;
  endtask

  task automatic set_alloc(input rob_tag_t tag, input logic [31:0] addr);
    lsu_if.instr_valid_i           = 1'b1;
    lsu_if.load_allocate_i         = 1'b1;
    lsu_if.load_allocate_addr_i    = addr;
    lsu_if.load_allocate_mask_i    = 4'hF;
    lsu_if.load_allocate_rob_tag_i = tag;
    lsu_if.load_store_set_pc_i     = pc_of(tag);
    lsu_if.load_store_set_id_i     = id_of(tag);
  endtask

  task automatic set_store(input rob_tag_t tag, input logic [31:0] addr,
                           input logic exp_hit, input rob_tag_t hit_tag);
    exp_t e;
    lsu_if.instr_valid_i       = 1'b1;
    lsu_if.store_instruction_i = 1'b1;
    lsu_if.store_addr_i        = addr;
    lsu_if.store_rob_tag_i     = tag;
    if (exp_hit) begin
      e.cyc = cyc + 1;
      e.pc  = pc_of(hit_tag);
      e.id  = id_of(hit_tag);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_alloc(input rob_tag_t tag, input logic [31:0] addr);
    set_alloc(tag, addr);
    step();
    clear_req();
  endtask

  task automatic do_store(input rob_tag_t tag, input logic [31:0] addr,
                          input logic exp_hit, input rob_tag_t hit_tag);
    set_store(tag, addr, exp_hit, hit_tag);
    step();
    clear_req();
    step();
  endtask

  task automatic do_flush();
    lsu_if.flush_i = 1'b1;
    step();
    clear_req();
  endtask

  // Monitor: every violation pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && lsu_if.violation_detect_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_violation: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("viol_cycle", cyc, e.cyc);
          chk("viol_pc", 32'(lsu_if.violation_load_pc_o), 32'(e.pc));
          chk("viol_id", 32'(lsu_if.violation_load_id_o), 32'(e.id));
        end
      end
    end
  end

  initial begin
    clear_req();
    lsu_if.rob_head_i = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_full", 32'(lsu_if.lb_full_o), 32'd0);
    chk("reset_detect", 32'(lsu_if.violation_detect_o), 32'd0);
    chk("reset_pc", 32'(lsu_if.violation_load_pc_o), 32'd0);
    chk("reset_id", 32'(lsu_if.violation_load_id_o), 32'd0);
    rst = 1'b0;
    step();

    // Basic violation: entry with tag 5 at 0x104 is younger than store tag 3.
    do_alloc(5'd4, 32'h100);
    do_alloc(5'd5, 32'h104);
    do_alloc(5'd6, 32'h200);
    do_store(5'd3, 32'h104, 1'b1, 5'd5);
    step();
    do_flush();

    // Older load, same word: no hit with head 0; hit once head moves to 6.
    do_alloc(5'd2, 32'h300);
    do_store(5'd7, 32'h302, 1'b0, 5'd0);
    lsu_if.rob_head_i = 5'd6;
    do_store(5'd7, 32'h302, 1'b1, 5'd2);
    lsu_if.rob_head_i = 5'd0;
    do_flush();

    // Two hits: the older load (tag 8) is reported.
    do_alloc(5'd10, 32'h400);
    do_alloc(5'd8, 32'h400);
    do_store(5'd5, 32'h400, 1'b1, 5'd8);
    do_flush();

    // Fill all 16 entries, overflow allocate ignored, commit frees one.
    for (int i = 0; i < 16; i++) begin
      do_alloc(rob_tag_t'(10 + i), 32'h1000 + 32'(4 * i));
    end
    chk("full_after_fill", 32'(lsu_if.lb_full_o), 32'd1);
    do_alloc(5'd30, 32'h2000);
    chk("full_after_overflow", 32'(lsu_if.lb_full_o), 32'd1);
    do_store(5'd1, 32'h2000, 1'b0, 5'd0);
    lsu_if.commit_valid_i   = 1'b1;
    lsu_if.commit_rob_tag_i = 5'd12;
    step();
    clear_req();
    chk("full_after_commit", 32'(lsu_if.lb_full_o), 32'd0);
    do_store(5'd1, 32'h1008, 1'b0, 5'd0);
    do_store(5'd1, 32'h1004, 1'b1, 5'd11);
    do_flush();

    // Store hit coinciding with flush: no pulse, buffer empty afterwards.
    do_alloc(5'd20, 32'h600);
    set_store(5'd3, 32'h600, 1'b0, 5'd0);
    lsu_if.flush_i = 1'b1;
    step();
    clear_req();
    step();
    do_store(5'd3, 32'h600, 1'b0, 5'd0);

    // Allocate and store in the same cycle: new load not checked until next cycle.
    set_alloc(5'd9, 32'h500);
    set_store(5'd1, 32'h500, 1'b0, 5'd0);
    step();
    clear_req();
    step();
    do_store(5'd1, 32'h500, 1'b1, 5'd9);

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #2;
    chk("midreset_full", 32'(lsu_if.lb_full_o), 32'd0);
    chk("midreset_detect", 32'(lsu_if.violation_detect_o), 32'd0);
    chk("midreset_pc", 32'(lsu_if.violation_load_pc_o), 32'd0);
    chk("midreset_id", 32'(lsu_if.violation_load_id_o), 32'd0);
    rst = 1'b0;
    step();
    do_store(5'd1, 32'h500, 1'b0, 5'd0);

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
